// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM for the RV32 core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives all datapath strobes and traps on illegal opcodes or memory timeouts. Optional: OPIMM_EN.
module main_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic [1:0] o_alu_op,
  output logic       o_fun7_mask,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_i_or_d,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_src,
  output logic       o_reg_write,
  output logic       o_mem_to_reg,
  output logic       o_illegal,
  output logic       o_bus_err,
  output logic [2:0] o_state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

`ifdef OPIMM_EN
  localparam logic LP_OPIMM = 1'b1;
`else
  localparam logic LP_OPIMM = 1'b0;
`endif

  localparam logic [TO_W-1:0] LP_TO_MAX = TO_W'(MEM_TIMEOUT);
  localparam logic            LP_TO_EN  = (MEM_TIMEOUT != 0);

  logic [2:0]      r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_illegal;
  logic            r_bus_err;

  logic [2:0]      w_next;
  logic [TO_W-1:0] w_to_inc;
  logic            w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_imm, w_legal;
  logic            w_timeout, w_illegal_hit;
  logic [1:0]      w_alu_op, w_alu_src_a, w_alu_src_b;
  logic            w_fun7_mask, w_mem_req, w_mem_we, w_i_or_d;
  logic            w_ir_write, w_pc_write, w_pc_src, w_reg_write, w_mem_to_reg;

  assign w_is_r   = (i_opcode == OP_R);
  assign w_is_lw  = (i_opcode == OP_LW);
  assign w_is_sw  = (i_opcode == OP_SW);
  assign w_is_beq = (i_opcode == OP_BEQ);
  assign w_is_imm = LP_OPIMM && (i_opcode == OP_IMM);
  assign w_legal  = w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_imm;
  assign w_to_inc = r_to_cnt + TO_W'(1);

  always_comb begin
    w_next        = r_state;
    w_alu_op      = 2'b00;
    w_fun7_mask   = 1'b0;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_i_or_d      = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_illegal_hit = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        if (i_mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b10;
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next        = S_TRAP;
          w_illegal_hit = 1'b1;
        end
      end
      S_EXEC: begin
        w_alu_src_a = 2'b01;
        if (w_is_r) begin
          w_alu_op = 2'b10;
          w_next   = S_WB;
        end else if (w_is_imm) begin
          w_alu_src_b = 2'b10;
          w_alu_op    = 2'b10;
          w_fun7_mask = 1'b1;
          w_next      = S_WB;
        end else if (w_is_lw || w_is_sw) begin
          w_alu_src_b = 2'b10;
          w_next      = S_MEM;
        end else begin
          // BEQ: rs1 - rs2 sets zero, which gates the PC load from ALUOut.
          w_alu_op   = 2'b01;
          w_pc_src   = 1'b1;
          w_pc_write = i_zero;
          w_next     = S_FETCH;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_i_or_d  = 1'b1;
        w_mem_we  = w_is_sw;
        if (i_mem_ready) begin
          w_next = w_is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_is_lw;
        w_next       = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    // A ready in the limit cycle completes the access, so it never traps.
    if (LP_TO_EN && w_mem_req && !i_mem_ready && (w_to_inc == LP_TO_MAX)) begin
      w_timeout = 1'b1;
      w_next    = S_TRAP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_to_cnt  <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_illegal_hit) begin
        r_illegal <= 1'b1;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
      if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))) begin
        r_to_cnt <= '0;
      end else if (w_mem_req && !i_mem_ready && (r_to_cnt != LP_TO_MAX)) begin
        r_to_cnt <= w_to_inc;
      end
    end
  end

  // Strobes are gated by rst_n so a request drops the instant reset asserts.
  assign o_alu_op     = rst_n ? w_alu_op    : 2'b00;
  assign o_alu_src_a  = rst_n ? w_alu_src_a : 2'b00;
  assign o_alu_src_b  = rst_n ? w_alu_src_b : 2'b00;
  assign o_fun7_mask  = rst_n & w_fun7_mask;
  assign o_mem_req    = rst_n & w_mem_req;
  assign o_mem_we     = rst_n & w_mem_we;
  assign o_i_or_d     = rst_n & w_i_or_d;
  assign o_ir_write   = rst_n & w_ir_write;
  assign o_pc_write   = rst_n & w_pc_write;
  assign o_pc_src     = rst_n & w_pc_src;
  assign o_reg_write  = rst_n & w_reg_write;
  assign o_mem_to_reg = rst_n & w_mem_to_reg;
  assign o_illegal    = r_illegal;
  assign o_bus_err    = r_bus_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed self-checking bench for main_control_fsm: instruction sequences, traps,
// timeout boundary and asynchronous reset mid-request.
module tb_main_control_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Flag bytes: {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write, mem_to_reg}
  localparam logic [7:0] F_NONE   = 8'b0000_0000;
  localparam logic [7:0] F_FWAIT  = 8'b1000_0000;
  localparam logic [7:0] F_FDONE  = 8'b1001_1000;
  localparam logic [7:0] F_MEMRD  = 8'b1010_0000;
  localparam logic [7:0] F_MEMWR  = 8'b1110_0000;
  localparam logic [7:0] F_WBALU  = 8'b0000_0010;
  localparam logic [7:0] F_WBMEM  = 8'b0000_0011;
  localparam logic [7:0] F_BEQTK  = 8'b0000_1100;
  localparam logic [7:0] F_BEQNT  = 8'b0000_0100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero, mem_ready;
  logic [1:0] alu_op, alu_src_a, alu_src_b;
  logic       fun7_mask, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
  logic       reg_write, mem_to_reg, illegal, bus_err;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_alu_op(alu_op), .o_fun7_mask(fun7_mask), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_i_or_d(i_or_d),
    .o_ir_write(ir_write), .o_pc_write(pc_write), .o_pc_src(pc_src),
    .o_reg_write(reg_write), .o_mem_to_reg(mem_to_reg), .o_illegal(illegal),
    .o_bus_err(bus_err), .o_state(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's state and strobes, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [1:0] aop,
                     input logic f7, input logic [1:0] a, input logic [1:0] b,
                     input logic [7:0] fl);
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".strobes"},
        32'({alu_op, fun7_mask, alu_src_a, alu_src_b, mem_req, mem_we, i_or_d,
             ir_write, pc_write, pc_src, reg_write, mem_to_reg}),
        32'({aop, f7, a, b, fl}));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, F_NONE);
    chk("reset.illegal", 32'(illegal), 32'd0);
    chk("reset.bus_err", 32'(bus_err), 32'd0);
    rst_n = 1'b1;

    // R-type, memory always ready
    opcode = OP_R; mem_ready = 1'b1;
    cyc("r.fetch",  3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    cyc("r.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
    cyc("r.exec",   3'd2, 2'b10, 1'b0, 2'b01, 2'b00, F_NONE);
    cyc("r.wb",     3'd4, 2'b00, 1'b0, 2'b00, 2'b00, F_WBALU);
    $display("[TB] R-type sequence checked");

    // LW with three wait cycles in MEM
    opcode = OP_LW;
    cyc("lw.fetch",  3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    cyc("lw.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
    cyc("lw.exec",   3'd2, 2'b00, 1'b0, 2'b01, 2'b10, F_NONE);
    mem_ready = 1'b0;
    repeat (3) cyc("lw.mem.wait", 3'd3, 2'b00, 1'b0, 2'b00, 2'b00, F_MEMRD);
    mem_ready = 1'b1;
    cyc("lw.mem.done", 3'd3, 2'b00, 1'b0, 2'b00, 2'b00, F_MEMRD);
    cyc("lw.wb",       3'd4, 2'b00, 1'b0, 2'b00, 2'b00, F_WBMEM);
    $display("[TB] LW sequence checked");

    // SW
    opcode = OP_SW;
    cyc("sw.fetch",  3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    cyc("sw.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
    cyc("sw.exec",   3'd2, 2'b00, 1'b0, 2'b01, 2'b10, F_NONE);
    cyc("sw.mem",    3'd3, 2'b00, 1'b0, 2'b00, 2'b00, F_MEMWR);
    $display("[TB] SW sequence checked");

    // BEQ taken, then not taken
    opcode = OP_BEQ; zero = 1'b1;
    cyc("beq1.fetch",  3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    cyc("beq1.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
    cyc("beq1.exec",   3'd2, 2'b01, 1'b0, 2'b01, 2'b00, F_BEQTK);
    zero = 1'b0;
    cyc("beq0.fetch",  3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    cyc("beq0.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
    cyc("beq0.exec",   3'd2, 2'b01, 1'b0, 2'b01, 2'b00, F_BEQNT);
    $display("[TB] BEQ sequences checked");

    // FETCH waits 15 cycles, ready on the 16th: no trap
    opcode = OP_R; mem_ready = 1'b0;
    repeat (15) cyc("to.wait", 3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FWAIT);
    mem_ready = 1'b1;
    cyc("to.ready16", 3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    chk("to.no_bus_err", 32'(bus_err), 32'd0);
    cyc("to.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
    cyc("to.exec",   3'd2, 2'b10, 1'b0, 2'b01, 2'b00, F_NONE);
    cyc("to.wb",     3'd4, 2'b00, 1'b0, 2'b00, 2'b00, F_WBALU);
    $display("[TB] timeout boundary (ready on limit cycle) checked");

    // OP-IMM
    opcode = OP_IMM;
    cyc("imm.fetch",  3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    cyc("imm.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
`ifdef OPIMM_EN
    cyc("imm.exec", 3'd2, 2'b10, 1'b1, 2'b01, 2'b10, F_NONE);
    cyc("imm.wb",   3'd4, 2'b00, 1'b0, 2'b00, 2'b00, F_WBALU);
    chk("imm.illegal", 32'(illegal), 32'd0);
`else
    cyc("imm.trap", 3'd7, 2'b00, 1'b0, 2'b00, 2'b00, F_NONE);
    chk("imm.illegal", 32'(illegal), 32'd1);
    do_reset();
`endif
    $display("[TB] OP-IMM sequence checked");

    // Illegal opcode traps after DECODE and holds
    opcode = OP_BAD; mem_ready = 1'b1;
    cyc("ill.fetch",  3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    cyc("ill.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      zero      = i[1];
      cyc("ill.trap", 3'd7, 2'b00, 1'b0, 2'b00, 2'b00, F_NONE);
      chk("ill.illegal", 32'(illegal), 32'd1);
      chk("ill.bus_err", 32'(bus_err), 32'd0);
    end
    do_reset();
    $display("[TB] illegal trap checked");

    // FETCH never ready: trap after 16 wait cycles
    opcode = OP_R; mem_ready = 1'b0; zero = 1'b0;
    repeat (16) cyc("tt.wait", 3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FWAIT);
    cyc("tt.trap", 3'd7, 2'b00, 1'b0, 2'b00, 2'b00, F_NONE);
    chk("tt.bus_err", 32'(bus_err), 32'd1);
    chk("tt.illegal", 32'(illegal), 32'd0);
    do_reset();
    $display("[TB] fetch timeout trap checked");

    // Reset asserted mid-MEM with mem_req high
    opcode = OP_LW; mem_ready = 1'b1;
    cyc("rm.fetch",  3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FDONE);
    cyc("rm.decode", 3'd1, 2'b00, 1'b0, 2'b10, 2'b10, F_NONE);
    cyc("rm.exec",   3'd2, 2'b00, 1'b0, 2'b01, 2'b10, F_NONE);
    mem_ready = 1'b0;
    #1;
    chk("rm.mem_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rm.mem_req_after", 32'(mem_req), 32'd0);
    chk("rm.state_after", 32'(state_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rm.refetch", 3'd0, 2'b00, 1'b0, 2'b00, 2'b01, F_FWAIT);
    $display("[TB] reset mid-MEM checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
